// File: rtl/dmem_arbiter.sv
// Two-requester arbiter sharing a single-port data memory between the CPU MEM stage and a DMA/debug port.
// CPU wins by default; a starvation counter forces a DMA grant after STARVE_MAX lost contested cycles.
module dmem_arbiter #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [31:0]       dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_ack_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  output logic              dma_rvalid_o,
  output logic [1:0]        gnt_state_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_datain_o,
  input  logic [DATA_W-1:0] mem_dataout_i
);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } gnt_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic              cpu_grant;
  logic              dma_grant;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic [3:0]        starve_q, starve_d;
  gnt_e              gnt_q, gnt_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic              dma_rvalid_q, dma_rvalid_d;

  // Address bits above ADDR_W are deliberately ignored (aliasing modulo 2^ADDR_W).
  logic              unused_addr_hi;
  assign unused_addr_hi = ^{cpu_addr_i[31:ADDR_W], dma_addr_i[31:ADDR_W]};

  assign dma_grant = dma_req_i & (~cpu_req_i | (starve_q == STARVE_LIM));
  assign cpu_grant = cpu_req_i & ~dma_grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (cpu_grant) begin
      sel_we    = cpu_we_i;
      sel_addr  = cpu_addr_i[ADDR_W-1:0];
      sel_wdata = cpu_wdata_i;
    end else if (dma_grant) begin
      sel_we    = dma_we_i;
      sel_addr  = dma_addr_i[ADDR_W-1:0];
      sel_wdata = dma_wdata_i;
    end
  end

  // Gating with rst_n keeps a reset that lands mid-access from committing a write.
  assign mem_we_o     = sel_we & rst_n;
  assign mem_addr_o   = {{(32-ADDR_W){1'b0}}, sel_addr};
  assign mem_datain_o = sel_wdata;

  assign cpu_rdata_o  = mem_dataout_i;
  assign cpu_stall_o  = cpu_req_i & ~cpu_grant;
  assign dma_ack_o    = dma_grant;
  assign dma_rdata_o  = dma_rdata_q;
  assign dma_rvalid_o = dma_rvalid_q;
  assign gnt_state_o  = gnt_q;

  always_comb begin
    starve_d     = starve_q;
    dma_rdata_d  = dma_rdata_q;
    dma_rvalid_d = 1'b0;
    gnt_d        = GNT_IDLE;

    if (dma_grant || !dma_req_i) begin
      starve_d = '0;
    end else if (starve_q < STARVE_LIM) begin
      starve_d = starve_q + 4'd1;
    end

    if (dma_grant && !dma_we_i) begin
      dma_rdata_d  = mem_dataout_i;
      dma_rvalid_d = 1'b1;
    end

    if (dma_grant) begin
      gnt_d = GNT_DMA;
    end else if (cpu_grant) begin
      gnt_d = GNT_CPU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= '0;
      gnt_q        <= GNT_IDLE;
      dma_rdata_q  <= '0;
      dma_rvalid_q <= 1'b0;
    end else begin
      starve_q     <= starve_d;
      gnt_q        <= gnt_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_rvalid_q <= dma_rvalid_d;
    end
  end

endmodule
